// File: rtl/fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO: width-agnostic Gray conversions and
// a parameter legality check used at elaboration.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs convert correctly at any width up to 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic bit fifo_params_ok(input int addr_w, input int sync_stages,
                                          input int af_thresh, input int ae_thresh);
        int depth;
        depth = 1 << addr_w;
        return (addr_w >= 2) && (sync_stages >= 2) &&
               (af_thresh >= 1) && (af_thresh <= depth - 1) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/async_fifo_gray_if.sv
// Producer/consumer handshake bundle of the dual-clock FIFO; master drives
// requests, slave (the FIFO) drives data, flags and levels.
interface async_fifo_gray_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              winc;
    logic [DATA_W-1:0] wdata;
    logic              wfull;
    logic              walmost_full;
    logic [ADDR_W:0]   wlevel;
    logic              woverflow;
    logic              rinc;
    logic [DATA_W-1:0] rdata;
    logic              rempty;
    logic              ralmost_empty;
    logic [ADDR_W:0]   rlevel;
    logic              runderflow;

    modport master (
        output winc, wdata, rinc,
        input  wfull, walmost_full, wlevel, woverflow,
        input  rdata, rempty, ralmost_empty, rlevel, runderflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output wfull, walmost_full, wlevel, woverflow,
        output rdata, rempty, ralmost_empty, rlevel, runderflow
    );
endinterface

// File: rtl/async_fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer; only one bit changes per
// source update so the captured vector is always a valid neighbouring pointer.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray pointers, registered full/empty, almost flags,
// per-domain fill levels and overflow/underflow pulses.
module async_fifo_gray
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = (1 << ADDR_W) - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic wclk,
    input  logic wrst_n,
    input  logic rclk,
    input  logic rrst_n,
    async_fifo_gray_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_L = PW'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_L = PW'(AE_THRESH);

    generate
        if (!fifo_params_ok(ADDR_W, SYNC_STAGES, AF_THRESH, AE_THRESH)) begin : g_bad_params
            $error("async_fifo_gray: illegal parameter combination");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wbin, wgray, wq_rgray, wbin_next, wgray_next, wlevel_next;
    logic [ADDR_W:0] rbin, rgray, rq_wgray, rbin_next, rgray_next, rlevel_next;
    logic            w_acc, r_acc;

    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk(wclk), .rst_n(wrst_n), .d(rgray), .q(wq_rgray)
    );
    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk(rclk), .rst_n(rrst_n), .d(wgray), .q(rq_wgray)
    );

    // Write domain: the level uses the stale read pointer, so it can only overstate.
    always_comb begin
        w_acc       = bus.winc && !bus.wfull;
        wbin_next   = wbin + PW'(w_acc);
        wgray_next  = PW'(bin2gray(32'(wbin_next)));
        wlevel_next = wbin_next - PW'(gray2bin(32'(wq_rgray)));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin             <= '0;
            wgray            <= '0;
            bus.wfull        <= 1'b0;
            bus.walmost_full <= 1'b0;
            bus.wlevel       <= '0;
            bus.woverflow    <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            wgray            <= wgray_next;
            bus.wfull        <= wgray_next == {~wq_rgray[ADDR_W -: 2], wq_rgray[ADDR_W-2:0]};
            bus.walmost_full <= wlevel_next >= AF_L;
            bus.wlevel       <= wlevel_next;
            bus.woverflow    <= bus.winc && bus.wfull;
        end
    end

    always_ff @(posedge wclk) begin
        if (w_acc) mem[wbin[ADDR_W-1:0]] <= bus.wdata;
    end

    // Read domain: the stale write pointer makes the level understate, never overstate.
    always_comb begin
        r_acc       = bus.rinc && !bus.rempty;
        rbin_next   = rbin + PW'(r_acc);
        rgray_next  = PW'(bin2gray(32'(rbin_next)));
        rlevel_next = PW'(gray2bin(32'(rq_wgray))) - rbin_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin              <= '0;
            rgray             <= '0;
            bus.rempty        <= 1'b1;
            bus.ralmost_empty <= 1'b1;
            bus.rlevel        <= '0;
            bus.runderflow    <= 1'b0;
        end else begin
            rbin              <= rbin_next;
            rgray             <= rgray_next;
            bus.rempty        <= rgray_next == rq_wgray;
            bus.ralmost_empty <= rlevel_next <= AE_L;
            bus.rlevel        <= rlevel_next;
            bus.runderflow    <= bus.rinc && bus.rempty;
        end
    end

    assign bus.rdata = mem[rbin[ADDR_W-1:0]];
endmodule

// File: tb/tb_async_fifo_gray.sv
// Self-checking bench for async_fifo_gray: table-driven fill, hand sequences for
// latency/underflow/reset, and a scoreboarded random-duty stream across wraps.
`timescale 1ns/10ps
module tb_async_fifo_gray;
    logic wclk = 1'b0, rclk = 1'b0;
    logic wrst_n = 1'b0, rrst_n = 1'b0;
    int   checks = 0, errors = 0;
    logic [7:0] sb[$];

    async_fifo_gray_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    async_fifo_gray #(
        .DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n), .bus(bus)
    );

    // 100 MHz write clock on integer ns edges, ~37 MHz read clock on half-ns edges.
    always #5 wclk = ~wclk;
    always #13.5 rclk = ~rclk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wstep(input logic inc, input logic [7:0] d);
        @(negedge wclk);
        bus.winc  = inc;
        bus.wdata = d;
        @(posedge wclk);
        #0.2;
        bus.winc = 1'b0;
    endtask

    task automatic rstep(input logic inc);
        @(negedge rclk);
        bus.rinc = inc;
        if (inc && sb.size() > 0) chk("rdata", bus.rdata, sb.pop_front());
        @(posedge rclk);
        #0.2;
        bus.rinc = 1'b0;
    endtask

    task automatic wait_rlevel(input logic [4:0] lvl, input string nm);
        int n = 0;
        while (bus.rlevel !== lvl && n < 20) begin
            @(posedge rclk);
            #0.2;
            n++;
        end
        chk(nm, bus.rlevel, lvl);
    endtask

    // Concurrent producer/consumer with random duty; neither side requests when flagged.
    task automatic stream(input int n, input logic [7:0] base);
        int wc = 0, rc = 0;
        int wduty = $urandom_range(30, 90);
        int rduty = $urandom_range(30, 90);
        fork
            begin
                int cyc = 0;
                while (wc < n && cyc < 30000) begin
                    @(negedge wclk);
                    cyc++;
                    if (!bus.wfull) chk("nonfull_occupancy", sb.size() < 16, 1);
                    bus.winc  = !bus.wfull && ($urandom_range(1, 100) <= wduty);
                    bus.wdata = base + 8'(wc);
                    if (bus.winc) begin
                        sb.push_back(bus.wdata);
                        wc++;
                    end
                    @(posedge wclk);
                    #0.2;
                    chk("woverflow_stream", bus.woverflow, 0);
                    bus.winc = 1'b0;
                end
            end
            begin
                int cyc = 0;
                while (rc < n && cyc < 30000) begin
                    @(negedge rclk);
                    cyc++;
                    chk("empty_and_full", bus.rempty && bus.wfull, 0);
                    if (!bus.rempty) chk("nonempty_occupancy", sb.size() > 0, 1);
                    bus.rinc = !bus.rempty && ($urandom_range(1, 100) <= rduty);
                    if (bus.rinc) begin
                        chk("stream_rdata", bus.rdata, sb.pop_front());
                        rc++;
                    end
                    @(posedge rclk);
                    #0.2;
                    chk("runderflow_stream", bus.runderflow, 0);
                    bus.rinc = 1'b0;
                end
            end
        join
        chk("stream_writes_done", wc, n);
        chk("stream_reads_done", rc, n);
    endtask

    typedef struct {
        logic       winc;
        logic [7:0] wdata;
        logic       push;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } wvec_t;
    wvec_t tbl[18];

    initial begin
        bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 8'(i), 1'b1, (i == 15), (i + 1 >= 14), 5'(i + 1), 1'b0};
        tbl[16] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0};

        // Reset values
        repeat (3) @(posedge wclk);
        #0.2;
        chk("rst_wfull", bus.wfull, 0);
        chk("rst_walmost_full", bus.walmost_full, 0);
        chk("rst_wlevel", bus.wlevel, 0);
        chk("rst_woverflow", bus.woverflow, 0);
        chk("rst_rempty", bus.rempty, 1);
        chk("rst_ralmost_empty", bus.ralmost_empty, 1);
        chk("rst_rlevel", bus.rlevel, 0);
        chk("rst_runderflow", bus.runderflow, 0);
        @(negedge wclk);
        wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (4) @(posedge rclk);

        // Fill with no reads, then one dropped write
        for (int i = 0; i < 18; i++) begin
            wstep(tbl[i].winc, tbl[i].wdata);
            if (tbl[i].push) sb.push_back(tbl[i].wdata);
            chk($sformatf("fill%0d_wfull", i), bus.wfull, tbl[i].full);
            chk($sformatf("fill%0d_walmost_full", i), bus.walmost_full, tbl[i].af);
            chk($sformatf("fill%0d_wlevel", i), bus.wlevel, tbl[i].lvl);
            chk($sformatf("fill%0d_woverflow", i), bus.woverflow, tbl[i].ovf);
        end

        // Drain in order
        wait_rlevel(5'd16, "fill_rlevel");
        for (int k = 1; k <= 16; k++) begin
            rstep(1'b1);
            chk($sformatf("drain%0d_rlevel", k), bus.rlevel, 16 - k);
            chk($sformatf("drain%0d_rempty", k), bus.rempty, k == 16);
            chk($sformatf("drain%0d_ralmost_empty", k), bus.ralmost_empty, (16 - k) <= 2);
        end
        repeat (5) @(posedge wclk);
        #0.2;
        chk("drained_wlevel", bus.wlevel, 0);
        chk("drained_wfull", bus.wfull, 0);
        chk("drained_walmost_full", bus.walmost_full, 0);

        // Write-to-read latency: empty drops at the third rclk edge
        wstep(1'b1, 8'h5C);
        sb.push_back(8'h5C);
        for (int e = 1; e <= 3; e++) begin
            @(posedge rclk);
            #0.2;
            chk($sformatf("lat_edge%0d_rempty", e), bus.rempty, e < 3);
        end
        chk("lat_rdata", bus.rdata, 8'h5C);
        chk("lat_rlevel", bus.rlevel, 1);
        rstep(1'b1);
        chk("lat_pop_rempty", bus.rempty, 1);

        // Underflow pulse and almost-empty threshold
        rstep(1'b1);
        chk("uf_runderflow", bus.runderflow, 1);
        chk("uf_rlevel", bus.rlevel, 0);
        rstep(1'b0);
        chk("uf_runderflow_clear", bus.runderflow, 0);
        for (int i = 0; i < 3; i++) begin
            wstep(1'b1, 8'h30 + 8'(i));
            sb.push_back(8'h30 + 8'(i));
        end
        wait_rlevel(5'd2, "ae_rlevel2");
        chk("ae_at2", bus.ralmost_empty, 1);
        wait_rlevel(5'd3, "ae_rlevel3");
        chk("ae_at3", bus.ralmost_empty, 0);
        for (int i = 0; i < 3; i++) rstep(1'b1);
        chk("ae_drained_rempty", bus.rempty, 1);

        // 1000 bytes over many pointer wraps, duty re-randomised per chunk
        for (int c = 0; c < 4; c++) stream(250, 8'(c * 250));

        // Mid-stream reset with 9 words queued
        for (int i = 0; i < 9; i++) begin
            wstep(1'b1, 8'hC0 + 8'(i));
            sb.push_back(8'hC0 + 8'(i));
        end
        wait_rlevel(5'd9, "mid_rlevel9");
        chk("mid_wlevel9", bus.wlevel, 9);
        @(negedge wclk);
        wrst_n = 1'b0; rrst_n = 1'b0;
        sb.delete();
        @(posedge wclk);
        #0.2;
        chk("mid_rst_wfull", bus.wfull, 0);
        chk("mid_rst_wlevel", bus.wlevel, 0);
        chk("mid_rst_walmost_full", bus.walmost_full, 0);
        @(posedge rclk);
        #0.2;
        chk("mid_rst_rempty", bus.rempty, 1);
        chk("mid_rst_rlevel", bus.rlevel, 0);
        chk("mid_rst_ralmost_empty", bus.ralmost_empty, 1);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (4) @(posedge rclk);
        stream(20, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
